// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: bus-2 main-memory line controller.
// Fixed-latency line reads/writes as beat bursts on shared c2/d2.
module mem_line_ctrl #(
  parameter int         ADDR2_W     = 14,
  parameter int         DATA2_W     = 16,
  parameter int         LINE_BITS   = 128,
  parameter int         MEM_LATENCY = 100,
  parameter logic [7:0] SEED        = 8'h00
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic [ADDR2_W-1:0] a2,
  inout  wire  [DATA2_W-1:0] d2,
  inout  wire  [1:0]         c2,
  output logic               busy,
  output logic               proto_err,
  output logic [15:0]        rd_cnt,
  output logic [15:0]        wr_cnt
);
  localparam int BEATS = LINE_BITS / DATA2_W;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [CW-1:0] LAT  = CW'(MEM_LATENCY);
  localparam logic [1:0] C2_RESP = 2'd1;
  localparam logic [1:0] C2_RD   = 2'd2;
  localparam logic [1:0] C2_WR   = 2'd3;

  typedef enum logic [2:0] {
    IDLE, WR_RECV, WAIT, RD_SEND, WR_ACK
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR2_W-1:0] addr_q;
  logic is_wr_q;
  logic [BEATS-1:0][DATA2_W-1:0] line_q;
  logic cmd_rd, cmd_wr, a2_x;
  logic accept, err, commit, load, cap;

  // Each line is stored XORed with its power-up pattern,
  // so a zero-cleared array reads back as the seeded contents.
  logic [LINE_BITS-1:0] mem [2**ADDR2_W];

  function automatic logic [LINE_BITS-1:0] pat(
    input logic [ADDR2_W-1:0] a
  );
    pat = '0;
    for (int j = 0; j < LINE_BITS / 8; j++) begin
      pat[8*j +: 8] = 8'(a * (LINE_BITS / 8) + j) ^ SEED;
    end
  endfunction

  assign cmd_rd = (c2 == C2_RD);
  assign cmd_wr = (c2 == C2_WR);
  assign a2_x   = $isunknown(a2);
  assign busy   = (state_q != IDLE);

  assign c2 = (state_q == RD_SEND || state_q == WR_ACK)
              ? C2_RESP : 2'bzz;
  assign d2 = (state_q == RD_SEND)
              ? line_q[cnt_q[BW-1:0]] : {DATA2_W{1'bz}};

  // State register; reset aborts any transaction at once.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, latency/beat counter and datapath strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    accept  = 1'b0;
    err     = 1'b0;
    commit  = 1'b0;
    load    = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_rd || cmd_wr) begin
          if (a2_x) begin
            err = 1'b1;
          end else begin
            accept  = 1'b1;
            cnt_d   = CW'(1);
            state_d = cmd_wr ? WR_RECV : WAIT;
          end
        end
      end
      WR_RECV: begin
        cap = 1'b1;
        if (cnt_q == LAST) state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == LAT) begin
          cnt_d   = '0;
          commit  = is_wr_q;
          load    = !is_wr_q;
          state_d = is_wr_q ? WR_ACK : RD_SEND;
        end
      end
      RD_SEND: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      WR_ACK: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (state_q != IDLE && (cmd_rd || cmd_wr)) err = 1'b1;
  end

  // Command latch, beat buffer, status and counters.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      line_q    <= '0;
      proto_err <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (err) proto_err <= 1'b1;
      if (accept) begin
        addr_q    <= a2;
        is_wr_q   <= cmd_wr;
        line_q[0] <= d2;
        if (cmd_wr) wr_cnt <= wr_cnt + 16'd1;
        else        rd_cnt <= rd_cnt + 16'd1;
      end
      if (cap)  line_q[cnt_q[BW-1:0]] <= d2;
      if (load) line_q <= mem[addr_q] ^ pat(addr_q);
    end
  end

  // Whole-line commit, only once all beats are in.
  always_ff @(posedge clk) begin
    if (commit) mem[addr_q] <= line_q ^ pat(addr_q);
  end
endmodule
